branch_predictor_table: RTL
===========================

Name: branch_predictor_table

Overview:
- Parametrised successor to the single 2-bit saturating-counter predictor.
- Holds a table of 2^INDEX_BITS saturating counters of CTR_BITS each, indexed by fetch PC.
- When HIST_BITS > 0, the index is optionally XORed with a global branch history register (gshare mode).
- Sits beside fetch: a lookup returns a registered prediction one cycle later; execute writes the resolved outcome back via the update port.

Parameters:
- PC_WIDTH, 32, width of lookup_pc.
- INDEX_BITS, 6, log2 of the table depth (64 entries); must satisfy 1 <= INDEX_BITS <= PC_WIDTH-2.
- CTR_BITS, 2, width of each saturating counter; must be >= 1.
- HIST_BITS, 4, global history length; 0 selects pure bimodal; must be <= INDEX_BITS.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- clear  input  1  synchronous, active-high reset.
- lookup_en  input  1  request a prediction this cycle.
- lookup_pc  input  PC_WIDTH  fetch PC of the branch.
- pred_valid  output  1  prediction outputs are valid (one cycle after lookup_en).
- pred_taken  output  1  1 = predict taken, 0 = predict not taken.
- pred_index  output  INDEX_BITS  table index used; carried down the pipe for update.
- update_en  input  1  write back a resolved branch.
- update_index  input  INDEX_BITS  index returned by the original lookup.
- update_taken  input  1  resolved outcome (1 = taken).

Behaviour:
- Reset, while clear = 1 at a clock edge:
  - every counter is set to weakly-not-taken, 2^(CTR_BITS-1)-1 (2'b01 for CTR_BITS = 2);
  - history is set to 0;
  - pred_valid, pred_taken and pred_index are set to 0.
  - Reset overrides any lookup_en or update_en in the same cycle; neither takes effect.
  - A lookup issued in the cycle before clear is still presented in the cycle clear is asserted; it does not survive into the following cycle.
- Index computation (combinational from lookup_pc and the current registered history):
  - raw index = lookup_pc[INDEX_BITS+1:2] (word-aligned PCs).
  - If HIST_BITS > 0: index = raw ^ zero-extended history, with history in the low bits.
- Lookup latency: 1 cycle.
  - At the edge where lookup_en = 1: pred_valid <= 1, pred_index <= index, pred_taken <= MSB of the counter value seen by the read.
  - At an edge where lookup_en = 0: pred_valid <= 0. pred_taken and pred_index hold their previous values and are don't-care.
- Update, at an edge where update_en = 1:
  - if update_taken = 1, counter[update_index] increments, saturating at 2^CTR_BITS-1;
  - if update_taken = 0, it decrements, saturating at 0.
  - If HIST_BITS > 0, history <= {history[HIST_BITS-2:0], update_taken}. For HIST_BITS = 1, history <= update_taken.
  - History is non-speculative: it changes only on updates.
- Simultaneous lookup and update in the same cycle:
  - The lookup index uses the pre-update history.
  - If the lookup index equals update_index, the read returns the post-update counter value (write-to-read bypass). pred_taken reflects the new MSB.
- Updates with no outstanding lookup are legal. Back-to-back updates to the same index every cycle must each take effect.
- No backpressure: lookup and update are each accepted every cycle.
- Storage may be flops or an inferred RAM with bypass logic. Observable behaviour must match the rules above.

Test Plan:
- Reset (defaults): clear 1 cycle, then lookup_en with lookup_pc = 0x40 -> next cycle pred_valid = 1, pred_index = 0x10, pred_taken = 0. Cycle after (lookup_en = 0) -> pred_valid = 0.
- Saturation (HIST_BITS = 0):
  - 3 updates of index 5 with taken = 1 -> counter 01→10→11→11; lookup of pc 0x14 gives pred_taken = 1.
  - Then 1 not-taken update -> 10, still taken; a 2nd not-taken update -> 01, pred_taken = 0.
  - 2 more not-taken updates -> counter held at 00.
- History (defaults): after clear, updates with taken = 1,0,1,1 (any index) -> history = 4'b1011; lookup pc 0x0 gives pred_index = 0x0B. Lookup pc 0x2C gives pred_index = 0x0B ^ 0x0B = 0x00.
- Bypass (HIST_BITS = 0): index 3 at 01; in the same cycle, update_en (index 3, taken = 1) and lookup_en (pc 0x0C) -> pred_taken = 1 next cycle, pred_index = 3.
- Clear mid-operation: train index 7 to 11, then assert clear with lookup_en = 1 (pc 0x1C) in the same cycle -> next cycle pred_valid = 0. A following lookup of pc 0x1C gives pred_taken = 0 (counter back to 01).
- Width generality: CTR_BITS = 3, INDEX_BITS = 2, HIST_BITS = 2 -> reset counters = 3'b011. 1 taken update -> 100, predict taken. 4 further taken updates -> saturate at 111. Index wraps: pc 0x10 maps to raw index 0.

Source files
------------

// File: rtl/branch_predictor_table.sv
// Branch predictor table: 2^INDEX_BITS saturating counters indexed by fetch PC,
// optionally hashed with a non-speculative global history (gshare).
// Lookups return a registered prediction one cycle later; execute writes the
// resolved outcome back through the update port. Same-cycle update-to-lookup
// on the same index is bypassed so the lookup sees the post-update counter.
module branch_predictor_table #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned HIST_BITS  = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  lookup_en,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  update_en,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken
);

    localparam int unsigned Depth = 1 << INDEX_BITS;

    // Weakly-not-taken: the value just below the taken threshold.
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CtrMax  = '1;
    localparam logic [CTR_BITS-1:0] CtrOne  = CTR_BITS'(1);

    logic [CTR_BITS-1:0]   ctr_q [Depth];
    logic [INDEX_BITS-1:0] raw_index;
    logic [INDEX_BITS-1:0] hist_ext;
    logic [INDEX_BITS-1:0] lookup_index;
    logic [CTR_BITS-1:0]   upd_cur;
    logic [CTR_BITS-1:0]   upd_next;
    logic [CTR_BITS-1:0]   rd_ctr;

    // Only the word-aligned index bits of the PC feed the table.
    logic unused_pc;
    assign unused_pc = ^lookup_pc;

    assign raw_index = lookup_pc[INDEX_BITS+1:2];

    // Global history: shifts in each resolved outcome, never touched by lookups.
    if (HIST_BITS > 0) begin : g_hist
        logic [HIST_BITS-1:0] hist_q;

        if (HIST_BITS > 1) begin : g_shift
            // Shift the resolved outcome into the low end of the history.
            always_ff @(posedge clock) begin
                if (clear) begin
                    hist_q <= '0;
                end else if (update_en) begin
                    hist_q <= {hist_q[HIST_BITS-2:0], update_taken};
                end
            end
        end else begin : g_single
            // One-bit history simply remembers the last resolved outcome.
            always_ff @(posedge clock) begin
                if (clear) begin
                    hist_q <= '0;
                end else if (update_en) begin
                    hist_q <= update_taken;
                end
            end
        end

        // Zero-extend history into the index width, history in the low bits.
        always_comb begin
            hist_ext = '0;
            hist_ext[HIST_BITS-1:0] = hist_q;
        end
    end else begin : g_no_hist
        assign hist_ext = '0;
    end

    // Lookup hashes with the registered (pre-update) history.
    assign lookup_index = raw_index ^ hist_ext;

    // Saturating next value for the counter being updated.
    always_comb begin
        upd_cur  = ctr_q[update_index];
        upd_next = upd_cur;
        if (update_taken) begin
            if (upd_cur != CtrMax) begin
                upd_next = upd_cur + CtrOne;
            end
        end else begin
            if (upd_cur != '0) begin
                upd_next = upd_cur - CtrOne;
            end
        end
    end

    // Read port with write-to-read bypass for a same-cycle update of the same entry.
    always_comb begin
        rd_ctr = ctr_q[lookup_index];
        if (update_en && (update_index == lookup_index)) begin
            rd_ctr = upd_next;
        end
    end

    // Counter table: reset to weakly-not-taken, otherwise write the resolved update.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < Depth; i++) begin
                ctr_q[i] <= CtrInit;
            end
        end else if (update_en) begin
            ctr_q[update_index] <= upd_next;
        end
    end

    // Registered prediction; taken/index hold when no lookup is issued.
    always_ff @(posedge clock) begin
        if (clear) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= lookup_en;
            if (lookup_en) begin
                pred_taken <= rd_ctr[CTR_BITS-1];
                pred_index <= lookup_index;
            end
        end
    end

endmodule
